// File: rtl/bm_arb_pkg.sv
// rtl/bm_arb_pkg.sv - shared defaults, id-width helper and parity function for the parity arbiter
package bm_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int OPW_DEF     = 6;
    localparam int PAR_W       = 5;

    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic bm_parity(input logic [PAR_W-1:0] a, input logic [PAR_W-1:0] b);
        return (a[0] ^ b[2]) ^ (a[1] ^ b[2]) ^ (a[2] | (b[1] & b[0]))
             ^ (~a[3] | (b[3] & a[4])) ^ b[4];
    endfunction

endpackage

// File: rtl/bm_parity_core.sv
// rtl/bm_parity_core.sv - registered parity datapath shared by all requesters
module bm_parity_core
    import bm_arb_pkg::*;
(
    input  logic             clock,
    input  logic             resetn,
    input  logic             load_en,
    input  logic [PAR_W-1:0] a,
    input  logic [PAR_W-1:0] b,
    output logic             rsp_bit
);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rsp_bit <= 1'b0;
        end else if (load_en) begin
            rsp_bit <= bm_parity(a, b);
        end
    end

endmodule

// File: rtl/bm_parity_arbiter.sv
// rtl/bm_parity_arbiter.sv - round-robin arbiter in front of bm_parity_core; BM_GRANT_CNT_EN adds grant counters
module bm_parity_arbiter
    import bm_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int OPW     = OPW_DEF,
    parameter int IDW     = id_width(NUM_REQ)
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*OPW-1:0] req_a,
    input  logic [NUM_REQ*OPW-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic                   rsp_bit,
    output logic                   busy
`ifdef BM_GRANT_CNT_EN
    ,
    output logic [NUM_REQ*8-1:0]   grant_cnt
`endif
);

    localparam logic [IDW:0]   NUM_REQ_W = (IDW+1)'(NUM_REQ);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);

    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_found;
    logic [IDW:0]     cand;
    logic             can_issue;
    logic             transfer;
    logic [PAR_W-1:0] op_a;
    logic [PAR_W-1:0] op_b;

    assign can_issue = !rsp_valid || rsp_ready;
    // Ready is held low while reset is asserted, even though the grant search is combinational.
    assign transfer  = gnt_found && can_issue && resetn;
    assign busy      = rsp_valid || (|req_valid);

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (cand >= NUM_REQ_W) begin
                cand = cand - NUM_REQ_W;
            end
            if (!gnt_found && req_valid[cand[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        req_ready          = '0;
        req_ready[gnt_idx] = transfer;
    end

    assign op_a = req_a[int'(gnt_idx)*OPW +: PAR_W];
    assign op_b = req_b[int'(gnt_idx)*OPW +: PAR_W];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rr_ptr    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
        end else if (transfer) begin
            rr_ptr    <= (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;
            rsp_valid <= 1'b1;
            rsp_id    <= gnt_idx;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    bm_parity_core u_core (
        .clock   (clock),
        .resetn  (resetn),
        .load_en (transfer),
        .a       (op_a),
        .b       (op_b),
        .rsp_bit (rsp_bit)
    );

`ifdef BM_GRANT_CNT_EN
    logic [7:0] cnt [NUM_REQ];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (transfer && gnt_idx == IDW'(i) && cnt[i] != 8'hFF) begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt[i*8 +: 8] = cnt[i];
        end
    end
`endif

endmodule
